// File: rtl/hvac_output_sequencer.sv
// rtl/hvac_output_sequencer.sv - HVAC actuator sequencer with min-run, fan overrun and anti-short-cycle lockout
module hvac_output_sequencer #(
    parameter int MIN_ON_CYCLES      = 16,
    parameter int FAN_OVERRUN_CYCLES = 8,
    parameter int MIN_OFF_CYCLES     = 32,
    parameter int CNT_W              = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heater_en,
    output logic       compressor_en,
    output logic       fan_en,
    output logic       lockout_active,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEAT    = 3'd1,
        S_COOL    = 3'd2,
        S_OVERRUN = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    // Terminal counts are compared against the timer, which starts at 0 on entry.
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAN_LAST = CNT_W'(FAN_OVERRUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;

    // State register; reset drops straight to IDLE, ignoring any pending lockout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // State timer: restarts on every transition, otherwise counts up and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_d != state_q) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Next-state logic; conflicting requests in IDLE are never arbitrated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (heat_req && !cool_req) begin
                    state_d = S_HEAT;
                end else if (cool_req && !heat_req) begin
                    state_d = S_COOL;
                end
            end
            S_HEAT: begin
                if (!heat_req && (cnt >= ON_LAST)) begin
                    state_d = S_OVERRUN;
                end
            end
            S_COOL: begin
                if (!cool_req && (cnt >= ON_LAST)) begin
                    state_d = S_OVERRUN;
                end
            end
            S_OVERRUN: begin
                if (cnt == FAN_LAST) begin
                    state_d = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (cnt == OFF_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode straight from the state register.
    always_comb begin
        heater_en      = 1'b0;
        compressor_en  = 1'b0;
        fan_en         = 1'b0;
        lockout_active = 1'b0;
        case (state_q)
            S_HEAT: begin
                heater_en = 1'b1;
                fan_en    = 1'b1;
            end
            S_COOL: begin
                compressor_en = 1'b1;
                fan_en        = 1'b1;
            end
            S_OVERRUN: begin
                fan_en = 1'b1;
            end
            S_LOCKOUT: begin
                lockout_active = 1'b1;
            end
            default: begin
                heater_en = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_hvac_output_sequencer.sv
// tb/tb_hvac_output_sequencer.sv - directed table-driven bench for hvac_output_sequencer
module tb_hvac_output_sequencer;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HEAT = 3'd1;
    localparam logic [2:0] COOL = 3'd2;
    localparam logic [2:0] OVR  = 3'd3;
    localparam logic [2:0] LOCK = 3'd4;

    typedef struct {
        logic       heat;
        logic       cool;
        int         cycles;
        logic [2:0] st;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       heat_req = 1'b0;
    logic       cool_req = 1'b0;
    logic       heater_en, compressor_en, fan_en, lockout_active;
    logic [2:0] state;

    logic       heat2 = 1'b0;
    logic       cool2 = 1'b0;
    logic       heater2, comp2, fan2, lock2;
    logic [2:0] state2;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hvac_output_sequencer dut (
        .clk(clk), .reset(reset), .heat_req(heat_req), .cool_req(cool_req),
        .heater_en(heater_en), .compressor_en(compressor_en), .fan_en(fan_en),
        .lockout_active(lockout_active), .state(state)
    );

    hvac_output_sequencer #(
        .MIN_ON_CYCLES(1), .FAN_OVERRUN_CYCLES(1), .MIN_OFF_CYCLES(1), .CNT_W(4)
    ) dut_min (
        .clk(clk), .reset(reset), .heat_req(heat2), .cool_req(cool2),
        .heater_en(heater2), .compressor_en(comp2), .fan_en(fan2),
        .lockout_active(lock2), .state(state2)
    );

    // Expected {heater, compressor, fan, lockout, state} for a given state code.
    function automatic logic [6:0] exp_outs(input logic [2:0] s);
        logic h, c, f, l;
        h = (s == HEAT);
        c = (s == COOL);
        f = (s == HEAT) || (s == COOL) || (s == OVR);
        l = (s == LOCK);
        return {h, c, f, l, s};
    endfunction

    task automatic check_main(input string name, input logic [2:0] s);
        logic [6:0] got;
        logic [6:0] exp;
        got = {heater_en, compressor_en, fan_en, lockout_active, state};
        exp = exp_outs(s);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got{h,c,f,l,st}=%b required=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_min(input string name, input logic [2:0] s);
        logic [6:0] got;
        logic [6:0] exp;
        got = {heater2, comp2, fan2, lock2, state2};
        exp = exp_outs(s);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got{h,c,f,l,st}=%b required=%b", name, $time, got, exp);
        end
    endtask

    task automatic add(input logic h, input logic c, input int n, input logic [2:0] s, input string name);
        vec_t v;
        v.heat = h; v.cool = c; v.cycles = n; v.st = s; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive inputs, then for n edges check the main DUT just after each edge.
    task automatic run(input logic h, input logic c, input int n, input logic [2:0] s, input string name);
        heat_req = h;
        cool_req = c;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_main(name, s);
        end
    endtask

    task automatic run_min(input logic h, input logic c, input logic [2:0] s, input string name);
        heat2 = h;
        cool2 = c;
        @(posedge clk);
        #1;
        check_min(name, s);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog t=%0t simulation did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Short heat pulse
        add(1, 0, 1,   HEAT, "pulse_heat_start");
        add(0, 0, 15,  HEAT, "pulse_heat_minon");
        add(0, 0, 8,   OVR,  "pulse_overrun");
        add(0, 0, 32,  LOCK, "pulse_lockout");
        add(0, 0, 2,   IDLE, "pulse_idle");
        // Long cool request
        add(0, 1, 100, COOL, "long_cool_run");
        add(0, 0, 8,   OVR,  "long_cool_overrun");
        add(0, 0, 32,  LOCK, "long_cool_lockout");
        add(0, 0, 1,   IDLE, "long_cool_idle");
        // Changeover heat -> cool
        add(1, 0, 20,  HEAT, "chg_heat");
        add(0, 1, 8,   OVR,  "chg_overrun_cool_ignored");
        add(0, 1, 32,  LOCK, "chg_lockout_cool_ignored");
        add(0, 1, 1,   IDLE, "chg_idle_gap");
        add(0, 1, 1,   COOL, "chg_cool_start");
        add(0, 0, 15,  COOL, "chg_cool_minon");
        add(0, 0, 8,   OVR,  "chg_cool_overrun");
        add(0, 0, 32,  LOCK, "chg_cool_lockout");
        add(0, 0, 1,   IDLE, "chg_idle");
        // Conflict in IDLE
        add(1, 1, 10,  IDLE, "conflict_idle");
        add(1, 0, 1,   HEAT, "conflict_resolved_heat");
        add(0, 0, 15,  HEAT, "conflict_heat_minon");
        add(0, 0, 8,   OVR,  "conflict_overrun");
        add(0, 0, 32,  LOCK, "conflict_lockout");
        add(0, 0, 1,   IDLE, "conflict_idle_end");

        // Async reset state, before any clock edge
        #2;
        check_main("reset_main", IDLE);
        check_min("reset_min", IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].heat, vecs[i].cool, vecs[i].cycles, vecs[i].st, vecs[i].name);
        end

        // Reset in the middle of a cooling run, between edges
        run(0, 1, 5, COOL, "rst_cool_before");
        #3;
        reset = 1'b1;
        #1;
        check_main("rst_async_clear", IDLE);
        @(posedge clk);
        #1;
        check_main("rst_held", IDLE);
        @(negedge clk);
        reset = 1'b0;
        run(0, 1, 1, COOL, "rst_restart_no_lockout");
        run(0, 0, 15, COOL, "rst_cool_minon");
        run(0, 0, 8, OVR, "rst_overrun");
        run(0, 0, 32, LOCK, "rst_lockout");
        run(0, 0, 1, IDLE, "rst_idle");

        // Minimum parameter set: 1-cycle run, 1-cycle overrun, 1-cycle lockout
        run_min(1, 0, HEAT, "min_heat");
        run_min(0, 0, OVR,  "min_overrun");
        run_min(0, 0, LOCK, "min_lockout");
        run_min(0, 0, IDLE, "min_idle");
        run_min(0, 1, COOL, "min_cool");
        run_min(0, 0, OVR,  "min_cool_overrun");
        run_min(0, 0, LOCK, "min_cool_lockout");
        run_min(0, 0, IDLE, "min_cool_idle");
        run_min(1, 0, HEAT, "min_heat_again");
        run_min(1, 0, HEAT, "min_heat_held");
        run_min(0, 0, OVR,  "min_heat_again_overrun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hvac_output_sequencer.md
# hvac_output_sequencer

Downstream stage of the thermostat decision logic. Consumes the registered `heating`/`cooling` demand bits and drives the physical HVAC actuators (heater relay, compressor, blower fan). It enforces a minimum run time, a blower overrun after every run, and a compressor/heater anti-short-cycle lockout. All outputs are decoded from a single state register.

## Interface
- `MIN_ON_CYCLES`, default 16: minimum cycles the heater or compressor stays enabled once started; must be ≥1.
- `FAN_OVERRUN_CYCLES`, default 8: cycles the fan runs alone after heater/compressor switches off; must be ≥1.
- `MIN_OFF_CYCLES`, default 32: lockout cycles with everything off before a new run may start; must be ≥1.
- `CNT_W`, default 16: state-timer width; must hold max(parameters).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `heat_req`  in  1  heating demand from thermostat.
- `cool_req`  in  1  cooling demand from thermostat.
- `heater_en`  out  1  heater relay enable.
- `compressor_en`  out  1  compressor enable.
- `fan_en`  out  1  blower enable.
- `lockout_active`  out  1  high while in LOCKOUT.
- `state`  out  3  current state code, for debug and verification.

## Operation
- States and codes: IDLE=0, HEAT=1, COOL=2, OVERRUN=3, LOCKOUT=4. Codes 5–7 are unreachable; if entered, the next edge goes to IDLE.
- Timer `cnt` (CNT_W bits):
  - Cleared to 0 on every state transition.
  - Otherwise increments by 1 each cycle, saturating at all-ones.
- IDLE: all outputs 0.
  - `heat_req & !cool_req` → HEAT.
  - `cool_req & !heat_req` → COOL.
  - Both high or both low → stay IDLE. The conflict is never resolved by priority.
- HEAT: `heater_en=1`, `fan_en=1`.
  - Exit to OVERRUN when `!heat_req && cnt >= MIN_ON_CYCLES-1`.
  - `cool_req` is ignored while in HEAT.
- COOL: `compressor_en=1`, `fan_en=1`.
  - Exit to OVERRUN when `!cool_req && cnt >= MIN_ON_CYCLES-1`.
  - `heat_req` is ignored while in COOL.
- OVERRUN: `fan_en=1` only. Exit to LOCKOUT when `cnt == FAN_OVERRUN_CYCLES-1`. Requests are ignored.
- LOCKOUT: all actuators 0, `lockout_active=1`. Exit to IDLE when `cnt == MIN_OFF_CYCLES-1`. Requests are ignored.
- `heater_en` and `compressor_en` are never high in the same cycle.
- Changeover between heating and cooling always passes through OVERRUN and LOCKOUT.

## Timing
- Reset (async assert):
  - `state=IDLE`, `cnt=0`.
  - `heater_en`, `compressor_en`, `fan_en`, `lockout_active` all 0, immediately and without waiting for `clk`.
- Reset is released synchronously to `clk`. The first request is sampled on the first rising edge after deassertion.
- Outputs are Moore, decoded from the state register. There is no combinational path from inputs to outputs.
- Start latency: a request sampled high at edge k from IDLE makes the actuator output high immediately after edge k (one edge of latency).
- Run length is max(MIN_ON_CYCLES, request duration) cycles:
  - A request dropped early still yields exactly MIN_ON_CYCLES cycles of actuator high.
  - A request held longer ends at the first edge where it is sampled low.
- Fan stays high for run length + FAN_OVERRUN_CYCLES contiguous cycles.
- `lockout_active` is high for exactly MIN_OFF_CYCLES cycles.
- The earliest restart is sampled at the edge ending the first IDLE cycle. With a request held high continuously, the actuator rises MIN_OFF_CYCLES+1 cycles after the fan falls.
- Reset mid-operation aborts any state at once. The lockout is not honoured across reset; this is intentional, and power sequencing is owned elsewhere.
- Counter saturation: a run held longer than 2^CNT_W cycles keeps `cnt` at all-ones. The exit condition stays satisfied, with no wrap.

## Test plan
- Short heat pulse: `heat_req` high for 1 cycle from IDLE (defaults) → `heater_en` high exactly 16 cycles, `fan_en` high 24 cycles, `lockout_active` high 32 cycles, then `state=0`.
- Long cool request: `cool_req` high for 100 cycles → `compressor_en` high 100 cycles starting one edge after assertion, then fan-only 8 cycles, then lockout 32 cycles; `heater_en` stays 0 throughout.
- Changeover: `heat_req` held 20 cycles, then `cool_req` asserted and held during OVERRUN/LOCKOUT → `compressor_en` rises only after 32 lockout cycles plus 1 IDLE cycle; never overlaps `heater_en`.
- Conflict: `heat_req=cool_req=1` in IDLE for 10 cycles → all outputs stay 0, `state=0`; dropping `cool_req` → HEAT next edge.
- Reset mid-run: assert `reset` at cycle 5 of COOL, between clock edges → all outputs 0 before the next edge; after release with `cool_req` high, COOL is re-entered on the first edge, without lockout.
- Parameter sweep: MIN_ON=1, FAN_OVERRUN=1, MIN_OFF=1 with a 1-cycle request → heater 1 cycle, fan 2 cycles, lockout 1 cycle; no stuck states.
